logic_basic_queue_generic_arbiter: RTL and testbench



---
 rtl/logic_basic_queue_generic_arbiter.sv | 70 +++++++
 tb/tb_logic_basic_queue_generic_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/logic_basic_queue_generic_arbiter.sv
// logic_basic_queue_generic_arbiter: round-robin arbiter feeding a queue write port with occupancy tracking
module logic_basic_queue_generic_arbiter #(
  parameter int ADDRESS_WIDTH = 1,
  parameter int REQUESTERS = 2,
  parameter int DATA_WIDTH = 8,
  localparam int SOURCE_WIDTH = REQUESTERS > 1 ? $clog2(REQUESTERS) : 1,
  localparam int DEPTH = 2 ** ADDRESS_WIDTH
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [REQUESTERS-1:0]            rx_tvalid,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] rx_tdata,
  output logic [REQUESTERS-1:0]            rx_tready,
  input  logic                             read_enable,
  output logic                             write_enable,
  output logic [DATA_WIDTH-1:0]            write_data,
  output logic [SOURCE_WIDTH-1:0]          write_source,
  output logic [ADDRESS_WIDTH:0]           capacity,
  output logic                             full,
  output logic                             empty,
  output logic                             underflow
);
  localparam logic [ADDRESS_WIDTH:0] CAP_ONE = (ADDRESS_WIDTH+1)'(1);
  localparam logic [ADDRESS_WIDTH:0] CAP_DEPTH = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [SOURCE_WIDTH-1:0] SRC_ONE = SOURCE_WIDTH'(1);
  localparam logic [SOURCE_WIDTH-1:0] SRC_LAST = SOURCE_WIDTH'(REQUESTERS - 1);
  logic [SOURCE_WIDTH-1:0] p, winner;
  logic [DATA_WIDTH-1:0] sel_data;
  logic found, xfer, pop;
  int idx;
  // scan from the priority pointer upward; first valid requester wins
  always_comb begin
    found = 1'b0;
    winner = '0;
    sel_data = '0;
    idx = 0;
    for (int k = 0; k < REQUESTERS; k++) begin
      idx = (int'(p) + k) % REQUESTERS;
      if (!found && rx_tvalid[idx]) begin
        found = 1'b1;
        winner = SOURCE_WIDTH'(idx);
        sel_data = rx_tdata[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  assign full = capacity == CAP_DEPTH;
  assign empty = capacity == '0;
  assign rx_tready = (found && !full && !areset) ? REQUESTERS'(1) << winner : '0;
  assign xfer = |(rx_tvalid & rx_tready);
  assign pop = read_enable && !empty;
  always_ff @(posedge aclk) begin
    if (areset) begin
      capacity <= '0;
      p <= '0;
      write_enable <= 1'b0;
      write_data <= '0;
      write_source <= '0;
      underflow <= 1'b0;
    end else begin
      write_enable <= xfer;
      underflow <= read_enable && empty;
      capacity <= (xfer && !pop) ? capacity + CAP_ONE : (pop && !xfer) ? capacity - CAP_ONE : capacity;
      if (xfer) begin
        write_data <= sel_data;
        write_source <= winner;
        p <= winner == SRC_LAST ? '0 : winner + SRC_ONE;
      end
    end
  end
endmodule

// File: tb/tb_logic_basic_queue_generic_arbiter.sv
// tb_logic_basic_queue_generic_arbiter: directed vectors checked against a behavioural queue/arbiter model
module tb_logic_basic_queue_generic_arbiter;
  localparam int AW = 1, R = 3, DW = 8, SW = 2, DEPTH = 2;
  logic aclk = 1'b0, areset = 1'b1, read_enable = 1'b0;
  logic [R-1:0] rx_tvalid = '0, rx_tready;
  logic [R*DW-1:0] rx_tdata = '0;
  logic write_enable, full, empty, underflow;
  logic [DW-1:0] write_data;
  logic [SW-1:0] write_source;
  logic [AW:0] capacity;
  int errors = 0, checks = 0;
  int m_cap = 0, m_p = 0, m_ws = 0, g = -1;
  logic m_we = 1'b0, m_uf = 1'b0;
  logic [DW-1:0] m_wd = '0;
  bit m_ok = 1'b0;
  int fair_exp [6] = '{0, 1, 2, 0, 1, 2};

  logic_basic_queue_generic_arbiter #(.ADDRESS_WIDTH(AW), .REQUESTERS(R), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .areset(areset), .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata), .rx_tready(rx_tready),
    .read_enable(read_enable), .write_enable(write_enable), .write_data(write_data),
    .write_source(write_source), .capacity(capacity), .full(full), .empty(empty), .underflow(underflow));

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int grant_of();
    if (areset || m_cap >= DEPTH) return -1;
    for (int k = 0; k < R; k++)
      if (rx_tvalid[(m_p + k) % R]) return (m_p + k) % R;
    return -1;
  endfunction

  task automatic drive(input logic [R-1:0] v, input logic [R*DW-1:0] d, input logic re, input logic rst);
    @(negedge aclk);
    rx_tvalid = v;
    rx_tdata = d;
    read_enable = re;
    areset = rst;
    #1;
    g = grant_of();
    if (m_ok) begin
      check("capacity", 32'(capacity), m_cap);
      check("full", 32'(full), 32'(m_cap == DEPTH));
      check("empty", 32'(empty), 32'(m_cap == 0));
      check("write_enable", 32'(write_enable), 32'(m_we));
      check("write_data", 32'(write_data), 32'(m_wd));
      check("write_source", 32'(write_source), m_ws);
      check("underflow", 32'(underflow), 32'(m_uf));
      check("rx_tready", 32'(rx_tready), g < 0 ? 0 : 1 << g);
    end
  endtask

  task automatic tick();
    bit pop;
    @(posedge aclk);
    if (areset) begin
      m_cap = 0; m_p = 0; m_we = 0; m_wd = '0; m_ws = 0; m_uf = 0; m_ok = 1;
    end else begin
      pop = read_enable && m_cap > 0;
      m_uf = read_enable && m_cap == 0;
      m_we = g >= 0;
      if (g >= 0) begin
        m_wd = rx_tdata[g*DW +: DW];
        m_ws = g;
        m_p = (g + 1) % R;
      end
      m_cap = m_cap + (g >= 0 ? 1 : 0) - (pop ? 1 : 0);
    end
  endtask

  localparam logic [R*DW-1:0] TRIO = 24'h332211;

  initial begin
    drive('0, '0, 0, 1); tick();
    drive('0, '0, 0, 1); tick();
    drive('0, '0, 0, 0);
    check("rst_capacity", 32'(capacity), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_we", 32'(write_enable), 0);
    check("rst_uf", 32'(underflow), 0);
    tick();
    // prime: requester 2 transfers so capacity is 1 and priority returns to 0
    drive(3'b100, TRIO, 0, 0); tick();
    for (int k = 0; k < 6; k++) begin
      drive(3'b111, TRIO, 1, 0);
      check("fair_grant", 32'(rx_tready), 1 << fair_exp[k]);
      check("fair_capacity", 32'(capacity), 1);
      tick();
    end
    drive('0, TRIO, 1, 0);
    check("simul_we", 32'(write_enable), 1);
    check("simul_capacity", 32'(capacity), 1);
    check("fair_last_source", 32'(write_source), 2);
    check("fair_last_data", 32'(write_data), 32'h33);
    tick();
    drive('0, TRIO, 1, 0);
    check("drained", 32'(capacity), 0);
    tick();
    drive('0, TRIO, 0, 0);
    check("uf_pulse", 32'(underflow), 1);
    check("uf_capacity", 32'(capacity), 0);
    tick();
    drive('0, TRIO, 0, 0);
    check("uf_single", 32'(underflow), 0);
    tick();
    drive(3'b001, 24'h0000A1, 0, 0); tick();
    drive(3'b001, 24'h0000A2, 0, 0);
    check("fill_cap1", 32'(capacity), 1);
    check("fill_data1", 32'(write_data), 32'hA1);
    tick();
    drive(3'b001, 24'h0000A3, 0, 0);
    check("fill_cap2", 32'(capacity), 2);
    check("fill_full", 32'(full), 1);
    check("fill_stall", 32'(rx_tready), 0);
    tick();
    drive(3'b001, 24'h0000A3, 1, 0);
    check("full_pop_blocks", 32'(rx_tready), 0);
    tick();
    drive(3'b001, 24'h0000A3, 0, 0);
    check("resume_cap", 32'(capacity), 1);
    check("resume_grant", 32'(rx_tready), 1);
    tick();
    drive('0, '0, 0, 0);
    check("refill_cap", 32'(capacity), 2);
    check("refill_data", 32'(write_data), 32'hA3);
    tick();
    drive('0, '0, 0, 1); tick();
    drive('0, '0, 0, 0); tick();
    drive(3'b001, 24'h000055, 0, 0); tick();
    drive('0, '0, 0, 1);
    check("mid_cap", 32'(capacity), 1);
    tick();
    drive(3'b111, TRIO, 0, 0);
    check("mid_we_dropped", 32'(write_enable), 0);
    check("mid_cap_cleared", 32'(capacity), 0);
    check("mid_first_grant", 32'(rx_tready), 1);
    tick();
    drive('0, '0, 0, 0); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
